// File: rtl/mac_accumulator.sv
// mac_accumulator
//   Sequential signed multiply-accumulate engine. After start_mac it consumes
//   VEC_LEN accepted act/wgt beats through a 2-stage pipeline (registered
//   product, then saturating accumulate). It then pulses mac_done and holds
//   the final sum on result.
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   start_mac           start request, sampled in IDLE only
//   in_valid            act_in/wgt_in carry a beat this cycle (ACCUM only)
//   act_in, wgt_in      signed DATA_W operands
//   busy                high in ACCUM and DRAIN
//   mac_done            one-cycle completion pulse
//   result              final saturated sum, held until the next mac_done
//   result_valid        result holds a completed sum
//   overflow            sticky saturation flag for the current/last op
module mac_accumulator #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int VEC_LEN = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_mac,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] act_in,
    input  logic [DATA_W-1:0] wgt_in,
    output logic              busy,
    output logic              mac_done,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    output logic              overflow
);

    localparam int CNT_W = $clog2(VEC_LEN + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         beat_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  prod_q;
    logic                     prod_v;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W:0]      sum;
    logic                       sum_ovf;
    logic                       last_beat;
    logic                       drain_done;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    assign prod     = $signed(act_in) * $signed(wgt_in);
    assign prod_ext = ACC_W'(prod);

    // One guard bit: the sum overflowed when the two top bits disagree,
    // and the guard bit gives the true sign for the clamp direction.
    assign sum     = {acc[ACC_W-1], acc} + {prod_q[ACC_W-1], prod_q};
    assign sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];

    assign last_beat  = (state == ACCUM) && in_valid && (beat_cnt == CNT_W'(VEC_LEN - 1));
    // DRAIN is entered with the final product still in prod_q; finish once
    // it has been folded into acc (prod_v low).
    assign drain_done = (state == DRAIN) && !prod_v;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_mac)  state_nxt = ACCUM;
            ACCUM:   if (last_beat)  state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt     <= '0;
            acc          <= '0;
            prod_q       <= '0;
            prod_v       <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            mac_done     <= 1'b0;
        end else begin
            mac_done <= 1'b0;
            prod_v   <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_mac) begin
                        acc          <= '0;
                        beat_cnt     <= '0;
                        overflow     <= 1'b0;
                        result_valid <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        prod_q   <= prod_ext;
                        prod_v   <= 1'b1;
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        result       <= acc;
                        result_valid <= 1'b1;
                        mac_done     <= 1'b1;
                    end
                end
                default: ;
            endcase

            // prod_v is never high in IDLE, so this cannot collide with the
            // start-of-op clear above.
            if (prod_v) begin
                if (sum_ovf) begin
                    acc      <= sum[ACC_W] ? ACC_MIN : ACC_MAX;
                    overflow <= 1'b1;
                end else begin
                    acc <= sum[ACC_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: a default (ACC_W=24) and a narrow (ACC_W=16)
// instance share all stimulus; a plain-arithmetic saturating-sum model
// supplies expected results for both.
module tb_mac_accumulator;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_mac = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] act_in = '0;
    logic [7:0] wgt_in = '0;

    logic        busy24, done24, rv24, ovf24;
    logic [23:0] res24;
    logic        busy16, done16, rv16, ovf16;
    logic [15:0] res16;

    mac_accumulator #(.DATA_W(8), .ACC_W(24), .VEC_LEN(8)) d24 (
        .clk(clk), .reset_n(reset_n), .start_mac(start_mac), .in_valid(in_valid),
        .act_in(act_in), .wgt_in(wgt_in), .busy(busy24), .mac_done(done24),
        .result(res24), .result_valid(rv24), .overflow(ovf24));

    mac_accumulator #(.DATA_W(8), .ACC_W(16), .VEC_LEN(8)) d16 (
        .clk(clk), .reset_n(reset_n), .start_mac(start_mac), .in_valid(in_valid),
        .act_in(act_in), .wgt_in(wgt_in), .busy(busy16), .mac_done(done16),
        .result(res16), .result_valid(rv16), .overflow(ovf16));

    always #5 clk = ~clk;

    int     n_chk = 0;
    int     n_err = 0;
    int     acts[8];
    int     wgts[8];
    longint prev24 = 0;
    longint prev16 = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Saturating running sum of the current vector at the given width.
    task automatic model(input int accw, output longint s, output longint ov);
        longint mx, mn;
        mx = (longint'(1) << (accw - 1)) - 1;
        mn = -(longint'(1) << (accw - 1));
        s  = 0;
        ov = 0;
        for (int i = 0; i < 8; i++) begin
            s = s + longint'(acts[i]) * longint'(wgts[i]);
            if (s > mx)      begin s = mx; ov = 1; end
            else if (s < mn) begin s = mn; ov = 1; end
        end
    endtask

    task automatic rand_vec();
        for (int i = 0; i < 8; i++) begin
            acts[i] = int'($urandom_range(0, 255)) - 128;
            wgts[i] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic noise();
        act_in = 8'($urandom);
        wgt_in = 8'($urandom);
    endtask

    // Feed n beats of the current vector with up to gmax idle cycles before
    // each; optionally assert start_mac alongside beat 3 (must be ignored).
    task automatic feed(input int n, input int gmax, input bit mid_start);
        for (int i = 0; i < n; i++) begin
            int g;
            g = (gmax == 0) ? 0 : int'($urandom_range(0, gmax));
            repeat (g) begin
                in_valid = 1'b0;
                noise();
                @(negedge clk);
            end
            in_valid  = 1'b1;
            act_in    = 8'(acts[i]);
            wgt_in    = 8'(wgts[i]);
            start_mac = mid_start && (i == 3);
            @(negedge clk);
            start_mac = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    // Complete operation. chain=1 means we are sitting in the previous
    // op's mac_done cycle and start immediately.
    task automatic do_op(input string tag, input int gmax, input bit mid_start, input bit chain);
        longint e24, e16, o24, o16;
        model(24, e24, o24);
        model(16, e16, o16);
        if (!chain) begin
            in_valid = 1'b1;               // ignored in IDLE
            noise();
            @(negedge clk);
            chk({tag, ".idle_done"}, done24, 0);
        end
        start_mac = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        start_mac = 1'b0;
        chk({tag, ".busy"}, busy24, 1);
        if (chain) begin
            chk({tag, ".chain_rv"}, rv24, 0);
            chk({tag, ".chain_res_held"}, $signed(res24), prev24);
            chk({tag, ".chain_done_pulse"}, done24, 0);
        end
        feed(8, gmax, mid_start);
        // Now just past E0 (last beat edge); DRAIN must ignore in_valid.
        in_valid = 1'b1;
        noise();
        @(negedge clk);
        chk({tag, ".e1_done"}, done24, 0);
        chk({tag, ".e1_busy"}, busy24, 1);
        in_valid = 1'($urandom);
        noise();
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".e2_done"}, done24, 1);
        chk({tag, ".e2_busy"}, busy24, 0);
        chk({tag, ".rv"}, rv24, 1);
        chk({tag, ".res24"}, $signed(res24), e24);
        chk({tag, ".ovf24"}, ovf24, o24);
        chk({tag, ".res16"}, $signed(res16), e16);
        chk({tag, ".ovf16"}, ovf16, o16);
        chk({tag, ".done16"}, done16, 1);
        prev24 = e24;
        prev16 = e16;
    endtask

    initial begin
        // 1: reset with random inputs, then release with no start
        reset_n = 1'b0;
        repeat (5) begin
            start_mac = 1'($urandom);
            in_valid  = 1'($urandom);
            noise();
            @(negedge clk);
            chk("rst.busy", busy24, 0);
            chk("rst.done", done24, 0);
            chk("rst.rv", rv24, 0);
            chk("rst.ovf", ovf24, 0);
            chk("rst.res", res24, 0);
        end
        start_mac = 1'b0;
        in_valid  = 1'b0;
        reset_n   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst.busy", busy24, 0);
            chk("post_rst.done", done24, 0);
            chk("post_rst.rv", rv24, 0);
            chk("post_rst.res", res24, 0);
        end

        // 2: defaults, back-to-back
        for (int i = 0; i < 8; i++) begin acts[i] = i + 1; wgts[i] = 2; end
        do_op("b2b", 0, 1'b0, 1'b0);
        chk("b2b.const72", $signed(res24), 72);

        // 3: gapped input
        do_op("gap", 3, 1'b0, 1'b0);
        chk("gap.const72", $signed(res24), 72);

        // 4: signed / saturation
        for (int i = 0; i < 8; i++) begin acts[i] = 127; wgts[i] = 127; end
        do_op("satpos", 1, 1'b0, 1'b0);
        chk("satpos.const16", $signed(res16), 32767);
        for (int i = 0; i < 8; i++) begin acts[i] = -128; wgts[i] = 127; end
        do_op("satneg", 1, 1'b0, 1'b0);
        chk("satneg.const16", $signed(res16), -32768);
        chk("satneg.const24", $signed(res24), -130048);

        // 5: start during ACCUM ignored; start in the mac_done cycle accepted
        rand_vec();
        do_op("midstart", 2, 1'b1, 1'b0);
        rand_vec();
        do_op("chain", 1, 1'b0, 1'b1);

        // 6: reset mid-op, then a clean op
        rand_vec();
        start_mac = 1'b1;
        @(negedge clk);
        start_mac = 1'b0;
        feed(4, 1, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("midrst.busy", busy24, 0);
        chk("midrst.res", res24, 0);
        chk("midrst.rv", rv24, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("midrst.no_done", done24, 0);
            chk("midrst.idle", busy24, 0);
        end
        rand_vec();
        do_op("fresh", 2, 1'b0, 1'b0);

        // random ops, including large-magnitude vectors for saturation at 16 bits
        for (int k = 0; k < 12; k++) begin
            rand_vec();
            do_op("rand", 3, 1'($urandom), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
